// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse link sequencer: reset/enable handshake with timeouts and retries,
// then 3-byte packet assembly into a clamped absolute cursor and button state.
module ps2_mouse_ctrl #(
   parameter int MAX_X          = 639,
   parameter int MAX_Y          = 479,
   parameter int TIMEOUT_CYCLES = 2500000,
   parameter int RETRY_LIMIT    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   input  logic       tx_idle,
   input  logic       tx_done_tick,
   output logic       wr_ps2,
   output logic [7:0] tx_data,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [2:0] buttons,
   output logic       pkt_valid,
   output logic       init_done,
   output logic       error
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RETRY_W = $clog2(RETRY_LIMIT + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_LIMIT - 1);
   localparam logic signed [11:0] MAX_X_S    = 12'(MAX_X);
   localparam logic signed [11:0] MAX_Y_S    = 12'(MAX_Y);
   localparam logic [9:0]         MAX_X_U    = 10'(MAX_X);
   localparam logic [9:0]         MAX_Y_U    = 10'(MAX_Y);
   localparam logic [9:0]         HOME_X     = 10'((MAX_X + 1) / 2);
   localparam logic [9:0]         HOME_Y     = 10'((MAX_Y + 1) / 2);

   typedef enum logic [3:0] {
      S_SEND_RST     = 4'd0,
      S_WAIT_ACK_RST = 4'd1,
      S_WAIT_BAT     = 4'd2,
      S_WAIT_ID      = 4'd3,
      S_SEND_EN      = 4'd4,
      S_WAIT_ACK_EN  = 4'd5,
      S_PKT0         = 4'd6,
      S_PKT1         = 4'd7,
      S_PKT2         = 4'd8,
      S_UPDATE       = 4'd9,
      S_FAIL         = 4'd10
   } state_t;

   state_t               state_r;
   logic                 sent_r;
   logic [TIMER_W-1:0]   timer_r;
   logic [RETRY_W-1:0]   retry_r;
   logic [7:0]           b0_r, b1_r, b2_r;

   logic [7:0]           cmd_s;
   logic [7:0]           expect_s;
   state_t               resend_s;
   state_t               ok_next_s;
   logic                 timeout_s;
   logic signed [11:0]   dx_s, dy_s, sum_x_s, sum_y_s;
   logic [9:0]           new_x_s, new_y_s;

   // Per-state handshake decode: command byte, expected reply and successor states.
   always_comb begin
      cmd_s     = 8'hFF;
      expect_s  = 8'h00;
      resend_s  = S_SEND_RST;
      ok_next_s = S_SEND_RST;
      timeout_s = (timer_r == TIMER_LAST);
      if (state_r == S_SEND_EN) begin
         cmd_s = 8'hF4;
      end else begin
         cmd_s = 8'hFF;
      end
      case (state_r)
         S_WAIT_ACK_RST: begin expect_s = 8'hFA; resend_s = S_SEND_RST; ok_next_s = S_WAIT_BAT;    end
         S_WAIT_BAT:     begin expect_s = 8'hAA; resend_s = S_SEND_RST; ok_next_s = S_WAIT_ID;     end
         S_WAIT_ID:      begin expect_s = 8'h00; resend_s = S_SEND_RST; ok_next_s = S_SEND_EN;     end
         S_WAIT_ACK_EN:  begin expect_s = 8'hFA; resend_s = S_SEND_EN;  ok_next_s = S_PKT0;        end
         default:        begin expect_s = 8'h00; resend_s = S_SEND_RST; ok_next_s = S_SEND_RST;    end
      endcase
   end

   // Signed movement decode and clamp of the next cursor position.
   always_comb begin
      dx_s = 12'sd0;
      dy_s = 12'sd0;
      if (b0_r[6]) begin
         dx_s = 12'sd0;
      end else begin
         dx_s = {{3{b0_r[4]}}, b0_r[4], b1_r};
      end
      if (b0_r[7]) begin
         dy_s = 12'sd0;
      end else begin
         dy_s = {{3{b0_r[5]}}, b0_r[5], b2_r};
      end
      // PS/2 reports y up-positive while the screen counts downward.
      sum_x_s = $signed({2'b00, pos_x}) + dx_s;
      sum_y_s = $signed({2'b00, pos_y}) - dy_s;
      if (sum_x_s < 12'sd0) begin
         new_x_s = 10'd0;
      end else if (sum_x_s > MAX_X_S) begin
         new_x_s = MAX_X_U;
      end else begin
         new_x_s = sum_x_s[9:0];
      end
      if (sum_y_s < 12'sd0) begin
         new_y_s = 10'd0;
      end else if (sum_y_s > MAX_Y_S) begin
         new_y_s = MAX_Y_U;
      end else begin
         new_y_s = sum_y_s[9:0];
      end
   end

   // Main sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_SEND_RST;
         sent_r    <= 1'b0;
         timer_r   <= '0;
         retry_r   <= '0;
         b0_r      <= 8'h00;
         b1_r      <= 8'h00;
         b2_r      <= 8'h00;
         pos_x     <= HOME_X;
         pos_y     <= HOME_Y;
         buttons   <= 3'b000;
         wr_ps2    <= 1'b0;
         tx_data   <= 8'h00;
         pkt_valid <= 1'b0;
         init_done <= 1'b0;
         error     <= 1'b0;
      end else begin
         wr_ps2    <= 1'b0;
         pkt_valid <= 1'b0;
         case (state_r)
            S_SEND_RST, S_SEND_EN: begin
               timer_r <= '0;
               if (sent_r && tx_done_tick) begin
                  sent_r  <= 1'b0;
                  state_r <= (state_r == S_SEND_RST) ? S_WAIT_ACK_RST : S_WAIT_ACK_EN;
               end else if (!sent_r && tx_idle) begin
                  wr_ps2  <= 1'b1;
                  tx_data <= cmd_s;
                  sent_r  <= 1'b1;
               end
            end
            S_WAIT_ACK_RST, S_WAIT_BAT, S_WAIT_ID, S_WAIT_ACK_EN: begin
               if (rx_done_tick && (rx_data == expect_s)) begin
                  timer_r <= '0;
                  state_r <= ok_next_s;
                  if (state_r == S_WAIT_ACK_EN) begin
                     init_done <= 1'b1;
                  end
               end else if (rx_done_tick && (rx_data == 8'hFE)) begin
                  timer_r <= '0;
                  state_r <= resend_s;
               end else if (rx_done_tick || timeout_s) begin
                  timer_r <= '0;
                  retry_r <= retry_r + 1'b1;
                  if (retry_r == RETRY_LAST) begin
                     state_r   <= S_FAIL;
                     error     <= 1'b1;
                     init_done <= 1'b0;
                  end else begin
                     state_r <= S_SEND_RST;
                  end
               end else begin
                  timer_r <= timer_r + 1'b1;
               end
            end
            S_PKT0: begin
               timer_r <= '0;
               // Only a byte with the always-one bit set can start a packet.
               if (rx_done_tick && rx_data[3]) begin
                  b0_r    <= rx_data;
                  state_r <= S_PKT1;
               end
            end
            S_PKT1, S_PKT2: begin
               if (rx_done_tick) begin
                  timer_r <= '0;
                  if (state_r == S_PKT1) begin
                     b1_r    <= rx_data;
                     state_r <= S_PKT2;
                  end else begin
                     b2_r    <= rx_data;
                     state_r <= S_UPDATE;
                  end
               end else if (timeout_s) begin
                  timer_r <= '0;
                  state_r <= S_PKT0;
               end else begin
                  timer_r <= timer_r + 1'b1;
               end
            end
            S_UPDATE: begin
               timer_r   <= '0;
               pos_x     <= new_x_s;
               pos_y     <= new_y_s;
               buttons   <= b0_r[2:0];
               pkt_valid <= 1'b1;
               state_r   <= S_PKT0;
            end
            S_FAIL: begin
               timer_r   <= '0;
               error     <= 1'b1;
               init_done <= 1'b0;
            end
            default: begin
               timer_r <= '0;
               state_r <= S_SEND_RST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Randomized self-checking bench for ps2_mouse_ctrl against a cursor/handshake model.
module tb_ps2_mouse_ctrl;

   localparam int T = 64;

   logic       clk = 1'b0;
   logic       rst, rx_done_tick, tx_idle, tx_done_tick;
   logic [7:0] rx_data;
   logic       wr_ps2, pkt_valid, init_done, error;
   logic [7:0] tx_data;
   logic [9:0] pos_x, pos_y;
   logic [2:0] buttons;

   ps2_mouse_ctrl #(.MAX_X(639), .MAX_Y(479), .TIMEOUT_CYCLES(T), .RETRY_LIMIT(3)) dut (
      .clk(clk), .rst(rst), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
      .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .wr_ps2(wr_ps2), .tx_data(tx_data),
      .pos_x(pos_x), .pos_y(pos_y), .buttons(buttons), .pkt_valid(pkt_valid),
      .init_done(init_done), .error(error)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail = 0;
   int         pkt_cnt = 0;
   int         idle_viol = 0;
   logic [7:0] wr_q[$];
   int         mx, my;
   logic [2:0] mb;
   int         exp_pkt;

   // Passive monitor of transmit requests and packet pulses.
   always @(negedge clk) begin
      if (wr_ps2 === 1'b1) begin
         wr_q.push_back(tx_data);
         if (tx_idle !== 1'b1) idle_viol++;
      end
      if (pkt_valid === 1'b1) pkt_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      rx_data = b; rx_done_tick = 1'b1;
      tick(1);
      rx_done_tick = 1'b0;
      tick(1);
   endtask

   task automatic pulse_txd();
      tick(2);
      tx_done_tick = 1'b1;
      tick(1);
      tx_done_tick = 1'b0;
      tick(1);
   endtask

   task automatic wait_wr(input logic [7:0] exp, input string nm);
      int k;
      logic [7:0] got;
      k = 0;
      while (wr_q.size() == 0 && k < 2 * T + 50) begin
         tick(1);
         k++;
      end
      n_checks++;
      if (wr_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: no wr_ps2 pulse seen, required tx_data %02h", nm, exp);
      end else begin
         got = wr_q.pop_front();
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: tx_data got %02h required %02h", nm, got, exp);
         end
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   // Reference: interpret the packet arithmetically and move the model cursor.
   task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      int dx, dy;
      dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
      dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
      mx = clampi(mx + dx, 639);
      my = clampi(my - dy, 479);
      mb = b0[2:0];
      exp_pkt++;
   endtask

   task automatic check_pos(input string nm);
      n_checks++;
      if (pos_x !== 10'(mx) || pos_y !== 10'(my) || buttons !== mb) begin
         n_fail++;
         $display("FAIL %s: pos (%0d,%0d) btn %b required (%0d,%0d) btn %b", nm, pos_x, pos_y, buttons, mx, my, mb);
      end
      n_checks++;
      if (pkt_cnt !== exp_pkt) begin
         n_fail++;
         $display("FAIL %s: pkt_valid pulses %0d required %0d", nm, pkt_cnt, exp_pkt);
      end
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input string nm);
      pulse_rx(b0); pulse_rx(b1); pulse_rx(b2);
      model_pkt(b0, b1, b2);
      tick(2);
      check_pos(nm);
   endtask

   task automatic test_reset();
      rst = 1'b1; tx_idle = 1'b0;
      tick(3);
      n_checks++;
      if (pos_x !== 10'd320 || pos_y !== 10'd240 || buttons !== 3'b000 || wr_ps2 !== 1'b0 ||
          tx_data !== 8'h00 || pkt_valid !== 1'b0 || init_done !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: pos (%0d,%0d) btn %b wr %b tx %02h pv %b id %b err %b required (320,240) 000 0 00 0 0 0",
                  pos_x, pos_y, buttons, wr_ps2, tx_data, pkt_valid, init_done, error);
      end
      mx = 320; my = 240; mb = 3'b000;
      rst = 1'b0;
   endtask

   task automatic test_init();
      tick(10);
      n_checks++;
      if (wr_q.size() !== 0 || idle_viol !== 0) begin
         n_fail++;
         $display("FAIL init_idle: %0d transmits while tx_idle=0, required 0", wr_q.size());
      end
      tx_idle = 1'b1;
      wait_wr(8'hFF, "init_reset_cmd");
      pulse_txd();
      pulse_rx(8'hFA); pulse_rx(8'hAA); pulse_rx(8'h00);
      wait_wr(8'hF4, "init_enable_cmd");
      pulse_txd();
      n_checks++;
      if (init_done !== 1'b0) begin
         n_fail++;
         $display("FAIL init_early: init_done %b required 0 before FA", init_done);
      end
      pulse_rx(8'hFA);
      tick(2);
      n_checks++;
      if (init_done !== 1'b1 || wr_q.size() !== 0 || idle_viol !== 0) begin
         n_fail++;
         $display("FAIL init_done: init_done %b extra wr %0d viol %0d required 1 0 0", init_done, wr_q.size(), idle_viol);
      end
      check_pos("init_pos");
   endtask

   task automatic test_packets();
      send_pkt(8'h09, 8'h05, 8'h03, "pkt_basic");
      for (int i = 0; i < 3; i++) send_pkt(8'h38, 8'h80, 8'hFF, "pkt_neg_clamp");
      for (int i = 0; i < 25; i++)
         send_pkt(8'($urandom) | 8'h08, 8'($urandom), 8'($urandom), "pkt_random");
   endtask

   task automatic test_resync();
      pulse_rx(8'h00);
      for (int i = 0; i < 4; i++) pulse_rx(8'($urandom) & 8'hF7);
      tick(2);
      check_pos("resync_discard");
      send_pkt(8'h48, 8'h7F, 8'h00, "x_overflow");
      pulse_rx(8'h08); pulse_rx(8'h10);
      tick(T + 10);
      check_pos("interbyte_timeout");
      n_checks++;
      if (init_done !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_init_done: init_done %b required 1", init_done);
      end
      send_pkt(8'h08, 8'h01, 8'h00, "after_timeout");
   endtask

   task automatic test_reset_mid();
      pulse_rx(8'h09); pulse_rx(8'h05);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      mx = 320; my = 240; mb = 3'b000;
      pulse_rx(8'h03);
      tick(3);
      check_pos("reset_mid_packet");
      n_checks++;
      if (init_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_init: init_done %b required 0", init_done);
      end
   endtask

   task automatic test_retry();
      logic [7:0] bad;
      wait_wr(8'hFF, "restart_cmd");
      pulse_txd();
      pulse_rx(8'hFE);
      wait_wr(8'hFF, "resend_cmd");
      pulse_txd();
      wait_wr(8'hFF, "retry1_timeout");
      pulse_txd();
      bad = 8'($urandom_range(1, 200));
      if (bad == 8'hFA) bad = 8'h11;
      pulse_rx(bad);
      wait_wr(8'hFF, "retry2_mismatch");
      pulse_txd();
      tick(T + 5);
      n_checks++;
      if (error !== 1'b1 || init_done !== 1'b0) begin
         n_fail++;
         $display("FAIL retry_limit: error %b init_done %b required 1 0", error, init_done);
      end
      tick(3 * T);
      n_checks++;
      if (wr_q.size() !== 0 || error !== 1'b1) begin
         n_fail++;
         $display("FAIL fail_silent: %0d transmits error %b required 0 1", wr_q.size(), error);
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      n_checks++;
      if (error !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_clears_error: error %b required 0", error);
      end
      wait_wr(8'hFF, "after_fail_restart");
   endtask

   initial begin
      rst = 1'b1; rx_done_tick = 1'b0; tx_idle = 1'b0; tx_done_tick = 1'b0; rx_data = 8'h00;
      exp_pkt = 0;
      tick(1);
      test_reset();
      test_init();
      test_packets();
      test_resync();
      test_reset_mid();
      test_retry();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
